// File: rtl/ldl_period_pkg.sv
// Shared types for the period / pulse-width meter.
package ldl_period_pkg;

  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

  localparam int MODE_PERIOD = 0;

endpackage

// File: rtl/ldl_edge_det.sv
// One-cycle delay of a clk-synchronous level plus rise/fall strobes.
module ldl_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic sig_dly_q;
  logic sig_dly_d;

  always_comb begin
    sig_dly_d = din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sig_dly_q <= 1'b0;
    else      sig_dly_q <= sig_dly_d;
  end

  assign rise = din & ~sig_dly_q;
  assign fall = ~din & sig_dly_q;

endmodule

// File: rtl/ldl_period_meter.sv
// Period (MODE 0) or high-width meter with a one-entry valid/ready result buffer.
// Define LDL_PERIOD_MINMAX_EN to add the pmin/pmax result trackers.
module ldl_period_meter
  import ldl_period_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             sig,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf,
  output logic             drop
`ifdef LDL_PERIOD_MINMAX_EN
  ,
  output logic [WIDTH-1:0] pmin,
  output logic [WIDTH-1:0] pmax
`endif
);

  logic rise;
  logic fall;
  logic start;
  logic stop;
  logic capture;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             drop_q, drop_d;

  ldl_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (sig),
    .rise (rise),
    .fall (fall)
  );

  assign start = rise;
  assign stop  = (MODE == MODE_PERIOD) ? rise : fall;

  // clr dominates en; both abandon the running count and suppress capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    capture = 1'b0;
    cnt_inc = cnt_q + WIDTH'(1);
    if (clr) begin
      ovf_d   = 1'b0;
      cnt_d   = '0;
      state_d = en ? ARM : IDLE;
    end else if (!en) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (start) begin
            cnt_d   = WIDTH'(1);
            state_d = COUNT;
          end
        end
        COUNT: begin
          if (stop) begin
            capture = 1'b1;
            if (MODE == MODE_PERIOD) begin
              cnt_d = WIDTH'(1);
            end else begin
              cnt_d   = '0;
              state_d = ARM;
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_inc;
            if (cnt_inc == '1) ovf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A full, unaccepted buffer keeps its old result and the new one is dropped.
  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    drop_d     = 1'b0;
    if (capture) begin
      if (dout_vld_q && !dout_rdy) begin
        drop_d = 1'b1;
      end else begin
        dout_d     = cnt_q;
        dout_vld_d = 1'b1;
      end
    end else if (dout_vld_q && dout_rdy) begin
      dout_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      drop_q     <= drop_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign ovf      = ovf_q;
  assign drop     = drop_q;

`ifdef LDL_PERIOD_MINMAX_EN
  logic [WIDTH-1:0] pmin_q, pmin_d;
  logic [WIDTH-1:0] pmax_q, pmax_d;

  // Dropped results still count towards the extremes.
  always_comb begin
    pmin_d = pmin_q;
    pmax_d = pmax_q;
    if (clr) begin
      pmin_d = '1;
      pmax_d = '0;
    end else if (capture) begin
      if (cnt_q < pmin_q) pmin_d = cnt_q;
      if (cnt_q > pmax_q) pmax_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pmin_q <= '1;
      pmax_q <= '0;
    end else begin
      pmin_q <= pmin_d;
      pmax_q <= pmax_d;
    end
  end

  assign pmin = pmin_q;
  assign pmax = pmax_q;
`endif

endmodule
